// File: rtl/insfetch.sv
// Multithreaded instruction fetch stage: per-thread PC/active state, round-robin
// thread selection, combinational imem read and the IF/ID pipeline register.
module insfetch #(
    parameter int unsigned NUM_TRD  = 8,
    parameter int unsigned TRD_W    = 3,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flushIF,
    input  logic               jmp_en,
    input  logic [TRD_W-1:0]   jmp_trd,
    input  logic [31:0]        jmp_pc,
    input  logic               spawn_en,
    input  logic [TRD_W-1:0]   spawn_trd,
    input  logic [31:0]        spawn_pc,
    input  logic               kill_en,
    input  logic [TRD_W-1:0]   kill_trd,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        ins_dec,
    output logic [31:0]        pc_dec,
    output logic [TRD_W-1:0]   trd_dec,
    output logic               valid_dec,
    output logic [NUM_TRD-1:0] active_mask,
    output logic               spawn_err
);

    logic [31:0]        pc_q [NUM_TRD];
    logic [31:0]        pc_d [NUM_TRD];
    logic [NUM_TRD-1:0] active_q, active_d;
    logic [TRD_W-1:0]   last_q, last_d;
    logic [31:0]        ins_q, ins_d;
    logic [31:0]        pc_dec_q, pc_dec_d;
    logic [TRD_W-1:0]   trd_q, trd_d;
    logic               valid_q, valid_d;
    logic               spawn_err_q, spawn_err_d;

    logic [TRD_W-1:0]   sel;
    logic [TRD_W-1:0]   cand;
    logic               found;
    logic               any_act;
    logic               fetch;

    // Round-robin: first active thread strictly after the last issued one.
    always_comb begin
        sel     = '0;
        cand    = '0;
        found   = 1'b0;
        any_act = |active_q;
        for (int i = 1; i <= int'(NUM_TRD); i++) begin
            cand = last_q + TRD_W'(i);
            if (!found && active_q[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign imem_addr = any_act ? pc_q[sel] : pc_q[0];

    always_comb begin
        pc_d        = pc_q;
        active_d    = active_q;
        last_d      = last_q;
        ins_d       = ins_q;
        pc_dec_d    = pc_dec_q;
        trd_d       = trd_q;
        valid_d     = valid_q;
        spawn_err_d = 1'b0;

        fetch = !flushIF && !stall && any_act;

        if (flushIF) begin
            ins_d    = '0;
            pc_dec_d = '0;
            trd_d    = '0;
            valid_d  = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (any_act) begin
            ins_d    = imem_data;
            pc_dec_d = pc_q[sel];
            trd_d    = sel;
            valid_d  = 1'b1;
            last_d   = sel;
        end else begin
            ins_d    = '0;
            pc_dec_d = '0;
            trd_d    = '0;
            valid_d  = 1'b0;
        end

        // Later assignments override earlier ones: spawn > jump > increment.
        if (fetch) begin
            pc_d[sel] = pc_q[sel] + PC_STEP;
        end
        if (jmp_en && active_q[jmp_trd]) begin
            pc_d[jmp_trd] = jmp_pc;
        end
        if (spawn_en && !active_q[spawn_trd]) begin
            pc_d[spawn_trd]     = spawn_pc;
            active_d[spawn_trd] = 1'b1;
        end
        if (kill_en) begin
            active_d[kill_trd] = 1'b0;
        end

        // A simultaneous kill of the same thread suppresses the error.
        spawn_err_d = spawn_en && active_q[spawn_trd] && !(kill_en && (kill_trd == spawn_trd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < int'(NUM_TRD); t++) begin
                pc_q[t] <= '0;
            end
            pc_q[0]     <= RESET_PC;
            active_q    <= NUM_TRD'(1);
            last_q      <= TRD_W'(NUM_TRD - 1);
            ins_q       <= '0;
            pc_dec_q    <= '0;
            trd_q       <= '0;
            valid_q     <= 1'b0;
            spawn_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            active_q    <= active_d;
            last_q      <= last_d;
            ins_q       <= ins_d;
            pc_dec_q    <= pc_dec_d;
            trd_q       <= trd_d;
            valid_q     <= valid_d;
            spawn_err_q <= spawn_err_d;
        end
    end

    assign ins_dec     = ins_q;
    assign pc_dec      = pc_dec_q;
    assign trd_dec     = trd_q;
    assign valid_dec   = valid_q;
    assign active_mask = active_q;
    assign spawn_err   = spawn_err_q;

endmodule

// File: tb/tb_insfetch.sv
// Scoreboard bench for insfetch: stimulus pushes expected IF/ID contents, a monitor
// pops and compares them on the falling edge.
module tb_insfetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flushIF;
    logic        jmp_en;
    logic [2:0]  jmp_trd;
    logic [31:0] jmp_pc;
    logic        spawn_en;
    logic [2:0]  spawn_trd;
    logic [31:0] spawn_pc;
    logic        kill_en;
    logic [2:0]  kill_trd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ins_dec;
    logic [31:0] pc_dec;
    logic [2:0]  trd_dec;
    logic        valid_dec;
    logic [7:0]  active_mask;
    logic        spawn_err;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [2:0]  trd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    insfetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flushIF     (flushIF),
        .jmp_en      (jmp_en),
        .jmp_trd     (jmp_trd),
        .jmp_pc      (jmp_pc),
        .spawn_en    (spawn_en),
        .spawn_trd   (spawn_trd),
        .spawn_pc    (spawn_pc),
        .kill_en     (kill_en),
        .kill_trd    (kill_trd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .ins_dec     (ins_dec),
        .pc_dec      (pc_dec),
        .trd_dec     (trd_dec),
        .valid_dec   (valid_dec),
        .active_mask (active_mask),
        .spawn_err   (spawn_err)
    );

    assign imem_data = 32'hA000_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Fetched-instruction expectation: pc for a real issue, bubble otherwise.
    task automatic cyc(input logic v, input logic [31:0] p, input logic [2:0] t);
        exp_t e;
        @(posedge clk);
        e.v   = v;
        e.ins = v ? (32'hA000_0000 | p) : 32'h0;
        e.pc  = v ? p : 32'h0;
        e.trd = v ? t : 3'd0;
        exp_q.push_back(e);
        #1;
        stall    = 1'b0;
        flushIF  = 1'b0;
        jmp_en   = 1'b0;
        spawn_en = 1'b0;
        kill_en  = 1'b0;
    endtask

    // Held outputs during stall: same expectation as the last issue.
    task automatic cyc_raw(input exp_t e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        stall = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (valid_dec !== e.v || ins_dec !== e.ins || pc_dec !== e.pc ||
                    trd_dec !== e.trd) begin
                    bad++;
                    $display("FAIL ifid: got v=%b ins=%h pc=%h trd=%0d expected v=%b ins=%h pc=%h trd=%0d",
                             valid_dec, ins_dec, pc_dec, trd_dec, e.v, e.ins, e.pc, e.trd);
                end
            end
        end
    end

    initial begin : stim
        exp_t hold;
        rst_n = 1'b0; stall = 1'b0; flushIF = 1'b0;
        jmp_en = 1'b0; jmp_trd = '0; jmp_pc = '0;
        spawn_en = 1'b0; spawn_trd = '0; spawn_pc = '0;
        kill_en = 1'b0; kill_trd = '0;
        #12;
        chk("rst_valid", {31'b0, valid_dec}, 32'd0);
        chk("rst_ins", ins_dec, 32'd0);
        chk("rst_active", {24'b0, active_mask}, 32'h1);
        chk("rst_spawn_err", {31'b0, spawn_err}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        rst_n = 1'b1;

        // Thread 0 alone
        cyc(1, 32'h0, 0);
        cyc(1, 32'h1, 0);
        cyc(1, 32'h2, 0);
        spawn_en = 1; spawn_trd = 2; spawn_pc = 32'h100;
        cyc(1, 32'h3, 0);
        spawn_en = 1; spawn_trd = 5; spawn_pc = 32'h200;
        cyc(1, 32'h100, 2);
        cyc(1, 32'h200, 5);
        cyc(1, 32'h4, 0);
        cyc(1, 32'h101, 2);
        cyc(1, 32'h201, 5);
        cyc(1, 32'h5, 0);
        cyc(1, 32'h102, 2);

        // Stall 3 cycles: outputs frozen
        hold = '{v: 1'b1, ins: 32'hA000_0102, pc: 32'h102, trd: 3'd2};
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            cyc_raw(hold);
        end
        cyc(1, 32'h202, 5);
        cyc(1, 32'h6, 0);

        // Jump thread 2 on its fetching edge, then flush the wrong-path slot
        jmp_en = 1; jmp_trd = 2; jmp_pc = 32'h400;
        cyc(1, 32'h103, 2);
        flushIF = 1;
        cyc(0, 32'h0, 0);
        cyc(1, 32'h203, 5);
        cyc(1, 32'h7, 0);
        cyc(1, 32'h400, 2);

        // Spawn and kill the same inactive thread
        spawn_en = 1; spawn_trd = 3; spawn_pc = 32'h300;
        kill_en = 1; kill_trd = 3;
        cyc(1, 32'h204, 5);
        chk("spawn_kill_mask", {24'b0, active_mask}, 32'h25);
        chk("spawn_kill_err", {31'b0, spawn_err}, 32'd0);

        // Spawn of already-active thread 0
        spawn_en = 1; spawn_trd = 0; spawn_pc = 32'h999;
        cyc(1, 32'h8, 0);
        chk("spawn_err_pulse", {31'b0, spawn_err}, 32'd1);
        cyc(1, 32'h401, 2);
        chk("spawn_err_clear", {31'b0, spawn_err}, 32'd0);
        cyc(1, 32'h205, 5);
        cyc(1, 32'h9, 0);

        // Kill every thread; selected instruction still issues
        kill_en = 1; kill_trd = 0;
        cyc(1, 32'h402, 2);
        kill_en = 1; kill_trd = 2;
        cyc(1, 32'h206, 5);
        kill_en = 1; kill_trd = 5;
        cyc(1, 32'h207, 5);
        chk("all_killed_mask", {24'b0, active_mask}, 32'h0);
        cyc(0, 32'h0, 0);
        chk("idle_imem_addr", imem_addr, 32'hA);
        spawn_en = 1; spawn_trd = 7; spawn_pc = 32'h50;
        cyc(0, 32'h0, 0);
        cyc(1, 32'h50, 7);
        cyc(1, 32'h51, 7);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_active", {24'b0, active_mask}, 32'h1);
        chk("midrst_valid", {31'b0, valid_dec}, 32'd0);
        chk("midrst_imem_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 32'h0, 0);
        cyc(1, 32'h1, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
